// File: rtl/qtu_fmb_scan_pkg.sv
// -----------------------------------------------------------------------------
// qtu_pkg
// Shared types for the Q-table update / find-my-best engine.
//   WORD_WIDTH  : width of every packet and table field
//   qtu_state_t : sequencer states
//   nt_entry_t  : one neighbor-table entry {valid, id, energy, hops, qvalue}
// -----------------------------------------------------------------------------
package qtu_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UPD_SCAN  = 2'd1,
        UPD_WRITE = 2'd2,
        FMB_SCAN  = 2'd3
    } qtu_state_t;

    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] qvalue;
    } nt_entry_t;

endpackage

// File: rtl/qtu_fmb_scan_nt_best_cmp.sv
// -----------------------------------------------------------------------------
// nt_best_cmp
// Combinational ranking of a candidate neighbor against the current best.
// A candidate wins on a strictly higher Q, or on equal Q with strictly fewer
// hops. An exact tie does not win, so the earlier-scanned entry is kept.
// Ports:
//   cand_q, cand_hops : candidate Q value and hop count (unsigned)
//   best_q, best_hops : current best Q value and hop count (unsigned)
//   beats             : 1 when the candidate should replace the best
// -----------------------------------------------------------------------------
module nt_best_cmp
    import qtu_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic [WORD_WIDTH-1:0] cand_q,
    input  logic [WORD_WIDTH-1:0] cand_hops,
    input  logic [WORD_WIDTH-1:0] best_q,
    input  logic [WORD_WIDTH-1:0] best_hops,
    output logic                  beats
);

    logic q_higher;
    logic q_equal;
    logic hops_fewer;

    assign q_higher   = cand_q > best_q;
    assign q_equal    = cand_q == best_q;
    assign hops_fewer = cand_hops < best_hops;
    assign beats      = q_higher || (q_equal && hops_fewer);

endmodule

// File: rtl/qtu_fmb_scan.sv
// -----------------------------------------------------------------------------
// qtu_fmb_scan
// Multi-entry Q-table update and find-my-best scanner for an EER-RL node.
// Owns a neighbor table of NT_DEPTH entries. An accepted update request looks
// the source up (one entry per cycle), then either refines its Q with a
// shift-based learning rate or inserts it into the first free slot. A
// find-my-best request walks the table and reports the highest-Q, then
// fewest-hops neighbor.
//
// Ports:
//   clk, nrst            : clock, synchronous active-low reset
//   en                   : update request pulse (packet fields below)
//   fmb_start            : find-my-best request pulse
//   clear                : invalidate the whole table
//   fSourceID .. fChosenCH : packet fields latched on an accepted update
//   chosenCH             : this node's current cluster head
//   myQValue             : this node's own Q (for better_than_me)
//   nodeID .. nodeQValue : contents of the last entry written
//   neighborCount        : number of valid entries
//   bestID/Hops/QValue   : result of the last scan, best_valid if any entry
//   better_than_me       : best_valid && bestQValue > myQValue (unsigned)
//   busy                 : sequencer not idle
//   QTU_done, FMB_done, nt_full_drop : single-cycle completion pulses
//
// Table entries use qtu_pkg::nt_entry_t, so WORD_WIDTH here must match
// qtu_pkg::WORD_WIDTH.
// -----------------------------------------------------------------------------
module qtu_fmb_scan #(
    parameter  int WORD_WIDTH  = 16,
    parameter  int NT_DEPTH    = 8,
    parameter  int ALPHA_SHIFT = 2,
    localparam int CW          = $clog2(NT_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  fmb_start,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fChosenCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] myQValue,
    output logic [WORD_WIDTH-1:0] nodeID,
    output logic [WORD_WIDTH-1:0] nodeEnergy,
    output logic [WORD_WIDTH-1:0] nodeHops,
    output logic [WORD_WIDTH-1:0] nodeQValue,
    output logic [CW-1:0]         neighborCount,
    output logic [WORD_WIDTH-1:0] bestID,
    output logic [WORD_WIDTH-1:0] bestHops,
    output logic [WORD_WIDTH-1:0] bestQValue,
    output logic                  best_valid,
    output logic                  better_than_me,
    output logic                  busy,
    output logic                  QTU_done,
    output logic                  FMB_done,
    output logic                  nt_full_drop
);

    import qtu_pkg::*;

    localparam int            IW       = $clog2(NT_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NT_DEPTH - 1);

    // Q <- oldQ + ((newQ - oldQ) >>> ALPHA_SHIFT), one bit wider and signed so
    // the difference never wraps. The result lies between oldQ and newQ, so the
    // truncation back to WORD_WIDTH is lossless.
    function automatic logic [WORD_WIDTH-1:0] q_update(
        input logic [WORD_WIDTH-1:0] old_q,
        input logic [WORD_WIDTH-1:0] new_q
    );
        logic signed [WORD_WIDTH:0] diff;
        logic signed [WORD_WIDTH:0] sum;
        diff = $signed({1'b0, new_q}) - $signed({1'b0, old_q});
        sum  = $signed({1'b0, old_q}) + (diff >>> ALPHA_SHIFT);
        return sum[WORD_WIDTH-1:0];
    endfunction

    // Sequencer state and scan bookkeeping
    qtu_state_t    state_q;
    qtu_state_t    state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] free_idx_q;
    logic [IW-1:0] tgt_idx_q;
    logic          free_found_q;
    logic          tgt_hit_q;
    logic          mm_pend_q;

    // Neighbor table
    nt_entry_t     table_q [NT_DEPTH];

    // Latched packet
    logic [WORD_WIDTH-1:0] lat_id_q;
    logic [WORD_WIDTH-1:0] lat_hops_q;
    logic [WORD_WIDTH-1:0] lat_q_q;
    logic [WORD_WIDTH-1:0] lat_energy_q;

    // Running best during FMB_SCAN
    logic                  cur_valid_q;
    logic [WORD_WIDTH-1:0] cur_id_q;
    logic [WORD_WIDTH-1:0] cur_hops_q;
    logic [WORD_WIDTH-1:0] cur_q_q;

    // Registered outputs
    logic [WORD_WIDTH-1:0] node_id_q;
    logic [WORD_WIDTH-1:0] node_energy_q;
    logic [WORD_WIDTH-1:0] node_hops_q;
    logic [WORD_WIDTH-1:0] node_q_q;
    logic [CW-1:0]         count_q;
    logic [WORD_WIDTH-1:0] best_id_q;
    logic [WORD_WIDTH-1:0] best_hops_q;
    logic [WORD_WIDTH-1:0] best_q_q;
    logic                  best_valid_q;
    logic                  qtu_done_q;
    logic                  fmb_done_q;
    logic                  drop_q;

    // Control strobes from the next-state logic
    logic do_clear;
    logic acc_upd;
    logic acc_mm;
    logic acc_fmb;
    logic scan_hit;
    logic scan_ins;
    logic scan_drop;
    logic do_write;
    logic fmb_end;

    // Per-cycle view of the entry under the scan pointer
    logic                  upd_hit_now;
    logic                  slot_free_now;
    logic                  idx_last;
    logic                  cand_beats;
    logic                  fmb_take;
    logic [WORD_WIDTH-1:0] wr_q;

    assign upd_hit_now   = table_q[idx_q].valid && (table_q[idx_q].id == lat_id_q);
    assign slot_free_now = !table_q[idx_q].valid;
    assign idx_last      = idx_q == LAST_IDX;

    nt_best_cmp #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_best_cmp (
        .cand_q    (table_q[idx_q].qvalue),
        .cand_hops (table_q[idx_q].hops),
        .best_q    (cur_q_q),
        .best_hops (cur_hops_q),
        .beats     (cand_beats)
    );

    // With no running best yet, any valid entry is taken.
    assign fmb_take = table_q[idx_q].valid && (!cur_valid_q || cand_beats);

    assign wr_q = tgt_hit_q ? q_update(table_q[tgt_idx_q].qvalue, lat_q_q) : lat_q_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_clear  = 1'b0;
        acc_upd   = 1'b0;
        acc_mm    = 1'b0;
        acc_fmb   = 1'b0;
        scan_hit  = 1'b0;
        scan_ins  = 1'b0;
        scan_drop = 1'b0;
        do_write  = 1'b0;
        fmb_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (en) begin
                    if (fChosenCH != chosenCH) begin
                        acc_mm = 1'b1;
                    end else begin
                        acc_upd = 1'b1;
                        state_d = UPD_SCAN;
                    end
                end else if (fmb_start) begin
                    acc_fmb = 1'b1;
                    state_d = FMB_SCAN;
                end
            end
            UPD_SCAN: begin
                if (upd_hit_now) begin
                    scan_hit = 1'b1;
                    state_d  = UPD_WRITE;
                end else if (idx_last) begin
                    // The last entry itself may be the first free slot.
                    if (free_found_q || slot_free_now) begin
                        scan_ins = 1'b1;
                        state_d  = UPD_WRITE;
                    end else begin
                        scan_drop = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            UPD_WRITE: begin
                do_write = 1'b1;
                state_d  = IDLE;
            end
            FMB_SCAN: begin
                if (idx_last) begin
                    fmb_end = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NT_DEPTH; i++) begin
                table_q[i].valid <= 1'b0;
            end
            idx_q         <= '0;
            free_found_q  <= 1'b0;
            mm_pend_q     <= 1'b0;
            cur_valid_q   <= 1'b0;
            node_id_q     <= '0;
            node_energy_q <= '0;
            node_hops_q   <= '0;
            node_q_q      <= '0;
            count_q       <= '0;
            best_id_q     <= '0;
            best_hops_q   <= '0;
            best_q_q      <= '0;
            best_valid_q  <= 1'b0;
            qtu_done_q    <= 1'b0;
            fmb_done_q    <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            // A chosenCH mismatch completes one cycle after acceptance.
            qtu_done_q <= mm_pend_q;
            fmb_done_q <= 1'b0;
            drop_q     <= 1'b0;
            mm_pend_q  <= acc_mm;

            if (do_clear) begin
                for (int i = 0; i < NT_DEPTH; i++) begin
                    table_q[i].valid <= 1'b0;
                end
                count_q      <= '0;
                best_valid_q <= 1'b0;
            end

            if (acc_upd) begin
                lat_id_q     <= fSourceID;
                lat_hops_q   <= fSourceHops;
                lat_q_q      <= fQValue;
                lat_energy_q <= fEnergyLeft;
                idx_q        <= '0;
                free_found_q <= 1'b0;
            end

            if (acc_fmb) begin
                idx_q       <= '0;
                cur_valid_q <= 1'b0;
            end

            // --- update scan: one entry per cycle ---
            if (state_q == UPD_SCAN) begin
                idx_q <= idx_last ? '0 : idx_q + IW'(1);
                if (slot_free_now && !free_found_q) begin
                    free_found_q <= 1'b1;
                    free_idx_q   <= idx_q;
                end
            end

            if (scan_hit) begin
                tgt_idx_q <= idx_q;
                tgt_hit_q <= 1'b1;
            end

            if (scan_ins) begin
                tgt_idx_q <= free_found_q ? free_idx_q : idx_q;
                tgt_hit_q <= 1'b0;
            end

            if (scan_drop) begin
                drop_q     <= 1'b1;
                qtu_done_q <= 1'b1;
            end

            // --- write back ---
            if (do_write) begin
                table_q[tgt_idx_q] <= '{valid:  1'b1,
                                        id:     lat_id_q,
                                        energy: lat_energy_q,
                                        hops:   lat_hops_q,
                                        qvalue: wr_q};
                node_id_q     <= lat_id_q;
                node_energy_q <= lat_energy_q;
                node_hops_q   <= lat_hops_q;
                node_q_q      <= wr_q;
                qtu_done_q    <= 1'b1;
                if (!tgt_hit_q) begin
                    count_q <= count_q + CW'(1);
                end
            end

            // --- find-my-best scan: one entry per cycle ---
            if (state_q == FMB_SCAN) begin
                idx_q <= idx_last ? '0 : idx_q + IW'(1);
                if (fmb_take) begin
                    cur_valid_q <= 1'b1;
                    cur_id_q    <= table_q[idx_q].id;
                    cur_hops_q  <= table_q[idx_q].hops;
                    cur_q_q     <= table_q[idx_q].qvalue;
                end
            end

            // The final entry is merged directly into the result so the best
            // outputs land together with FMB_done.
            if (fmb_end) begin
                fmb_done_q   <= 1'b1;
                best_valid_q <= fmb_take || cur_valid_q;
                if (fmb_take) begin
                    best_id_q   <= table_q[idx_q].id;
                    best_hops_q <= table_q[idx_q].hops;
                    best_q_q    <= table_q[idx_q].qvalue;
                end else if (cur_valid_q) begin
                    best_id_q   <= cur_id_q;
                    best_hops_q <= cur_hops_q;
                    best_q_q    <= cur_q_q;
                end else begin
                    best_id_q   <= '0;
                    best_hops_q <= '0;
                    best_q_q    <= '0;
                end
            end
        end
    end

    assign nodeID         = node_id_q;
    assign nodeEnergy     = node_energy_q;
    assign nodeHops       = node_hops_q;
    assign nodeQValue     = node_q_q;
    assign neighborCount  = count_q;
    assign bestID         = best_id_q;
    assign bestHops       = best_hops_q;
    assign bestQValue     = best_q_q;
    assign best_valid     = best_valid_q;
    assign better_than_me = best_valid_q && (best_q_q > myQValue);
    assign busy           = state_q != IDLE;
    assign QTU_done       = qtu_done_q;
    assign FMB_done       = fmb_done_q;
    assign nt_full_drop   = drop_q;

endmodule

// File: tb/tb_qtu_fmb_scan.sv
// -----------------------------------------------------------------------------
// tb_qtu_fmb_scan
// Directed bench for qtu_fmb_scan with NT_DEPTH=4, ALPHA_SHIFT=2. A table-level
// model predicts, per request, which cycle each pulse lands in and what the
// visible outputs become; a negedge process compares every cycle against it.
// Literal checks after each scenario pin the model's arithmetic.
// -----------------------------------------------------------------------------
module tb_qtu_fmb_scan;

    localparam int          W    = 16;
    localparam int          N    = 4;
    localparam int          A    = 2;
    localparam int          MAXC = 1024;
    localparam logic [15:0] CH   = 16'h0007;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          fmb_start;
    logic          clear;
    logic [W-1:0]  fSourceID;
    logic [W-1:0]  fSourceHops;
    logic [W-1:0]  fQValue;
    logic [W-1:0]  fEnergyLeft;
    logic [W-1:0]  fChosenCH;
    logic [W-1:0]  chosenCH;
    logic [W-1:0]  myQValue;
    logic [W-1:0]  nodeID;
    logic [W-1:0]  nodeEnergy;
    logic [W-1:0]  nodeHops;
    logic [W-1:0]  nodeQValue;
    logic [2:0]    neighborCount;
    logic [W-1:0]  bestID;
    logic [W-1:0]  bestHops;
    logic [W-1:0]  bestQValue;
    logic          best_valid;
    logic          better_than_me;
    logic          busy;
    logic          QTU_done;
    logic          FMB_done;
    logic          nt_full_drop;

    qtu_fmb_scan #(
        .WORD_WIDTH  (W),
        .NT_DEPTH    (N),
        .ALPHA_SHIFT (A)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .fmb_start      (fmb_start),
        .clear          (clear),
        .fSourceID      (fSourceID),
        .fSourceHops    (fSourceHops),
        .fQValue        (fQValue),
        .fEnergyLeft    (fEnergyLeft),
        .fChosenCH      (fChosenCH),
        .chosenCH       (chosenCH),
        .myQValue       (myQValue),
        .nodeID         (nodeID),
        .nodeEnergy     (nodeEnergy),
        .nodeHops       (nodeHops),
        .nodeQValue     (nodeQValue),
        .neighborCount  (neighborCount),
        .bestID         (bestID),
        .bestHops       (bestHops),
        .bestQValue     (bestQValue),
        .best_valid     (best_valid),
        .better_than_me (better_than_me),
        .busy           (busy),
        .QTU_done       (QTU_done),
        .FMB_done       (FMB_done),
        .nt_full_drop   (nt_full_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          count;
        logic [15:0] nid, nen, nh, nq;
        logic [15:0] bid, bh, bq;
        bit          bv;
    } vis_t;

    vis_t snap [MAXC];
    bit   has_snap [MAXC];
    bit   e_qtu [MAXC];
    bit   e_fmb [MAXC];
    bit   e_drop [MAXC];
    int   e_busy [MAXC];   // 0/1 expected, 2 = don't care
    vis_t ex;
    vis_t pend;

    bit          mv [N];
    logic [15:0] mid [N];
    logic [15:0] mq [N];
    logic [15:0] mh [N];
    int          idle_from = 0;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    function automatic vis_t zero_vis();
        vis_t v;
        v.count = 0; v.nid = 0; v.nen = 0; v.nh = 0; v.nq = 0;
        v.bid = 0; v.bh = 0; v.bq = 0; v.bv = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Learning-rate step with floor rounding of (new-old)/2^A.
    function automatic logic [15:0] qmodel(input logic [15:0] oldq, input logic [15:0] newq);
        int d, s, r;
        d = int'(newq) - int'(oldq);
        if (d >= 0) s = d / (1 << A);
        else        s = -((-d + (1 << A) - 1) / (1 << A));
        r = int'(oldq) + s;
        return 16'(r);
    endfunction

    function automatic void sched_busy(input int acc, input int done);
        for (int c = acc + 1; c < done; c++) e_busy[c] = 1;
        e_busy[acc]  = 2;
        e_busy[done] = 2;
    endfunction

    // Model of one request sampled at edge 'acc'.
    function automatic void model_req(input int acc, input bit c_r, input bit e_r, input bit f_r,
                                      input logic [15:0] id, input logic [15:0] hops,
                                      input logic [15:0] q, input logic [15:0] energy,
                                      input logic [15:0] pch);
        int k, fr, done, maxq, minh;
        if (acc - 1 < idle_from) return;
        if (c_r) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            pend.count = 0;
            pend.bv    = 1'b0;
            snap[acc] = pend; has_snap[acc] = 1'b1;
            idle_from = acc;
        end else if (e_r) begin
            if (pch != CH) begin
                e_qtu[acc + 1] = 1'b1;
                e_busy[acc] = 2; e_busy[acc + 1] = 2;
                idle_from = acc;
            end else begin
                k = -1; fr = -1;
                for (int i = 0; i < N; i++) begin
                    if (k < 0 && mv[i] && mid[i] == id) k = i;
                    if (fr < 0 && !mv[i]) fr = i;
                end
                if (k >= 0) begin
                    mq[k] = qmodel(mq[k], q); mh[k] = hops;
                    done = acc + k + 2;
                    pend.nid = id; pend.nen = energy; pend.nh = hops; pend.nq = mq[k];
                end else if (fr >= 0) begin
                    mv[fr] = 1'b1; mid[fr] = id; mq[fr] = q; mh[fr] = hops;
                    done = acc + N + 1;
                    pend.count++;
                    pend.nid = id; pend.nen = energy; pend.nh = hops; pend.nq = q;
                end else begin
                    done = acc + N;
                    e_drop[done] = 1'b1;
                end
                e_qtu[done] = 1'b1;
                snap[done] = pend; has_snap[done] = 1'b1;
                sched_busy(acc, done);
                idle_from = done;
            end
        end else if (f_r) begin
            maxq = -1; minh = 1 << 20;
            for (int i = 0; i < N; i++) if (mv[i] && int'(mq[i]) > maxq) maxq = int'(mq[i]);
            for (int i = 0; i < N; i++)
                if (mv[i] && int'(mq[i]) == maxq && int'(mh[i]) < minh) minh = int'(mh[i]);
            pend.bv = 1'b0; pend.bid = 0; pend.bh = 0; pend.bq = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (mv[i] && int'(mq[i]) == maxq && int'(mh[i]) == minh) begin
                    pend.bv = 1'b1; pend.bid = mid[i]; pend.bh = mh[i]; pend.bq = mq[i];
                end
            end
            done = acc + N;
            e_fmb[done] = 1'b1;
            snap[done] = pend; has_snap[done] = 1'b1;
            sched_busy(acc, done);
            idle_from = done;
        end
    endfunction

    function automatic void model_reset(input int r);
        for (int c = r; c < MAXC; c++) begin
            e_qtu[c] = 1'b0; e_fmb[c] = 1'b0; e_drop[c] = 1'b0;
            e_busy[c] = 0; has_snap[c] = 1'b0;
        end
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        pend = zero_vis();
        snap[r] = pend; has_snap[r] = 1'b1;
        idle_from = r;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            if (has_snap[cyc]) ex = snap[cyc];
            chk("QTU_done", 32'(QTU_done), 32'(e_qtu[cyc]));
            chk("FMB_done", 32'(FMB_done), 32'(e_fmb[cyc]));
            chk("nt_full_drop", 32'(nt_full_drop), 32'(e_drop[cyc]));
            if (e_busy[cyc] != 2) chk("busy", 32'(busy), 32'(e_busy[cyc]));
            chk("neighborCount", 32'(neighborCount), 32'(ex.count));
            chk("nodeID", 32'(nodeID), 32'(ex.nid));
            chk("nodeEnergy", 32'(nodeEnergy), 32'(ex.nen));
            chk("nodeHops", 32'(nodeHops), 32'(ex.nh));
            chk("nodeQValue", 32'(nodeQValue), 32'(ex.nq));
            chk("best_valid", 32'(best_valid), 32'(ex.bv));
            chk("bestID", 32'(bestID), 32'(ex.bid));
            chk("bestHops", 32'(bestHops), 32'(ex.bh));
            chk("bestQValue", 32'(bestQValue), 32'(ex.bq));
            chk("better_than_me", 32'(better_than_me), 32'(ex.bv && (ex.bq > myQValue)));
        end
    end

    task automatic drive_req(input bit c_r, input bit e_r, input bit f_r,
                             input logic [15:0] id, input logic [15:0] hops,
                             input logic [15:0] q, input logic [15:0] energy,
                             input logic [15:0] pch);
        @(posedge clk); #1;
        clear = c_r; en = e_r; fmb_start = f_r;
        fSourceID = id; fSourceHops = hops; fQValue = q; fEnergyLeft = energy; fChosenCH = pch;
        model_req(cyc + 1, c_r, e_r, f_r, id, hops, q, energy, pch);
        @(posedge clk); #1;
        clear = 1'b0; en = 1'b0; fmb_start = 1'b0;
    endtask

    task automatic upd(input logic [15:0] id, input logic [15:0] hops,
                       input logic [15:0] q, input logic [15:0] energy);
        drive_req(1'b0, 1'b1, 1'b0, id, hops, q, energy, CH);
        repeat (N + 2) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        drive_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, CH);
        @(posedge clk); #1;
    endtask

    task automatic do_fmb();
        drive_req(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, CH);
        repeat (N + 1) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        nrst = 1'b0;
        model_reset(cyc + 1);
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < MAXC; c++) begin
            snap[c] = zero_vis(); has_snap[c] = 1'b0;
            e_qtu[c] = 1'b0; e_fmb[c] = 1'b0; e_drop[c] = 1'b0; e_busy[c] = 0;
        end
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; mid[i] = 0; mq[i] = 0; mh[i] = 0;
        end
        ex = zero_vis(); pend = zero_vis();
        nrst = 1'b0; en = 1'b0; fmb_start = 1'b0; clear = 1'b0;
        fSourceID = 0; fSourceHops = 0; fQValue = 0; fEnergyLeft = 0; fChosenCH = 0;
        chosenCH = CH; myQValue = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        chk_en = 1'b1;
        chk("rst_count", 32'(neighborCount), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Insert then two hits on the same neighbor
        upd(16'd5, 16'd3, 16'h0100, 16'h0050);
        chk("ins_count", 32'(neighborCount), 32'd1);
        chk("ins_q", 32'(nodeQValue), 32'h0100);
        upd(16'd5, 16'd2, 16'h0200, 16'h0048);
        chk("hit_q_up", 32'(nodeQValue), 32'h0140);
        chk("hit_hops", 32'(nodeHops), 32'd2);
        upd(16'd5, 16'd2, 16'h0000, 16'h0040);
        chk("hit_q_down", 32'(nodeQValue), 32'h00F0);
        chk("hit_count", 32'(neighborCount), 32'd1);

        // Fill the table, overflow, hit on the last slot, chosenCH mismatch
        do_clear();
        chk("clr_count", 32'(neighborCount), 32'd0);
        for (int i = 1; i <= N; i++) upd(16'(i), 16'(i), 16'(i * 16'h10), 16'h0020);
        chk("full_count", 32'(neighborCount), 32'd4);
        upd(16'd9, 16'd1, 16'h0099, 16'h0011);
        chk("drop_count", 32'(neighborCount), 32'd4);
        chk("drop_node_id", 32'(nodeID), 32'd4);
        upd(16'd4, 16'd4, 16'h0080, 16'h0021);
        chk("hit3_q", 32'(nodeQValue), 32'h0050);
        drive_req(1'b0, 1'b1, 1'b0, 16'd7, 16'd1, 16'h0777, 16'h0001, CH + 16'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("mm_count", 32'(neighborCount), 32'd4);
        chk("mm_node_id", 32'(nodeID), 32'd4);

        // Find-my-best tie-break
        do_clear();
        upd(16'd11, 16'd3, 16'h0010, 16'h0001);
        upd(16'd12, 16'd2, 16'h0030, 16'h0002);
        upd(16'd13, 16'd1, 16'h0030, 16'h0003);
        upd(16'd14, 16'd1, 16'h0020, 16'h0004);
        do_fmb();
        chk("fmb_id", 32'(bestID), 32'd13);
        chk("fmb_hops", 32'(bestHops), 32'd1);
        chk("fmb_q", 32'(bestQValue), 32'h0030);
        chk("fmb_valid", 32'(best_valid), 32'd1);
        myQValue = 16'h0030;
        @(posedge clk); #1;
        chk("btm_eq", 32'(better_than_me), 32'd0);
        myQValue = 16'h002F;
        @(posedge clk); #1;
        chk("btm_lt", 32'(better_than_me), 32'd1);

        // Empty table scan
        do_clear();
        do_fmb();
        chk("empty_valid", 32'(best_valid), 32'd0);
        chk("empty_id", 32'(bestID), 32'd0);
        chk("empty_btm", 32'(better_than_me), 32'd0);

        // en and fmb_start together: only the update runs
        drive_req(1'b0, 1'b1, 1'b1, 16'd21, 16'd2, 16'h0044, 16'h0005, CH);
        repeat (N + 2) @(posedge clk);
        #1;
        chk("coll_count", 32'(neighborCount), 32'd1);
        chk("coll_id", 32'(nodeID), 32'd21);

        // en during FMB_SCAN is ignored
        drive_req(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, CH);
        drive_req(1'b0, 1'b1, 1'b0, 16'd22, 16'd1, 16'h0055, 16'h0006, CH);
        repeat (N + 2) @(posedge clk);
        #1;
        chk("busy_ign_count", 32'(neighborCount), 32'd1);
        chk("busy_ign_best", 32'(bestID), 32'd21);

        // Reset in the middle of an update scan
        drive_req(1'b0, 1'b1, 1'b0, 16'd23, 16'd1, 16'h0066, 16'h0007, CH);
        pulse_reset();
        repeat (N + 3) @(posedge clk);
        #1;
        chk("rst_mid_count", 32'(neighborCount), 32'd0);
        chk("rst_mid_node", 32'(nodeID), 32'd0);

        // Table usable again after the abort
        upd(16'd30, 16'd2, 16'h0123, 16'h0008);
        chk("post_rst_count", 32'(neighborCount), 32'd1);
        chk("post_rst_q", 32'(nodeQValue), 32'h0123);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
